// File: rtl/face_sched_pkg.sv
// Shared types and sizes for the face frame scheduler: the FSM state encoding,
// the cube geometry and a helper that extracts one face's orientation slice.
package face_sched_pkg;

  localparam int NUM_FACES  = 6;
  localparam int FACE_BITS  = 27;
  localparam int FRAME_BITS = 162;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_STREAM = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  function automatic logic [FACE_BITS-1:0] face_slice(input logic [FRAME_BITS-1:0] frame,
                                                      input logic [2:0]            idx);
    return frame[FACE_BITS*idx +: FACE_BITS];
  endfunction

endpackage

// File: rtl/face_frame_scheduler_cycle_timer.sv
// Up-counter with synchronous clear and enable; o_tc flags MAX_COUNT-1 and the
// count saturates there, so it serves as both a one-shot interval and an idle timer.
module cycle_timer #(
  parameter int unsigned MAX_COUNT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(MAX_COUNT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tc = (r_count == LAST);

endmodule

// File: rtl/face_frame_scheduler.sv
// Double-buffered cube frame scheduler: streams six faces with latch gaps, refreshes idle frames.
// First face_start 3 cycles after acceptance when idle; frame_ready drops while a frame is pending.
module face_frame_scheduler
  import face_sched_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES   = 2000,
  parameter int unsigned REFRESH_CYCLES = 4000000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_valid,
  input  logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_ready,
  output logic                  face_start,
  output logic [2:0]            face_sel,
  output logic [FACE_BITS-1:0]  face_orient,
  input  logic                  face_done,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [7:0]            frame_count
);

  state_t                r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_pending, r_active;
  logic                  r_pending_vld, r_active_vld, r_aborted;
  logic [2:0]            r_face_sel;
  logic [FACE_BITS-1:0]  r_face_orient;
  logic                  r_face_start, r_timeout_err;
  logic [7:0]            r_frame_count;

  logic w_accept, w_gap_tc, w_to_tc, w_ref_tc;
  logic w_load, w_refresh, w_next_face, w_to_fire, w_frame_end, w_last_face;

  assign w_accept    = frame_valid & ~r_pending_vld;
  assign w_last_face = (r_face_sel == 3'(NUM_FACES - 1));

  cycle_timer #(.MAX_COUNT(LATCH_CYCLES)) u_gap_timer (
    .clk(clk), .reset(reset), .i_clr(r_state != S_GAP), .i_en(r_state == S_GAP), .o_tc(w_gap_tc)
  );

  cycle_timer #(.MAX_COUNT(TIMEOUT_CYCLES)) u_timeout_timer (
    .clk(clk), .reset(reset), .i_clr(r_state != S_STREAM), .i_en(r_state == S_STREAM), .o_tc(w_to_tc)
  );

  cycle_timer #(.MAX_COUNT(REFRESH_CYCLES)) u_refresh_timer (
    .clk(clk), .reset(reset), .i_clr(r_state != S_IDLE), .i_en(r_state == S_IDLE), .o_tc(w_ref_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_refresh   = 1'b0;
    w_next_face = 1'b0;
    w_to_fire   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending_vld) begin
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (r_active_vld && w_ref_tc) begin
          w_refresh   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (face_done) begin
          w_state_nxt = S_GAP;
        end else if (w_to_tc) begin
          w_to_fire   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (w_gap_tc) begin
          if (w_last_face || r_aborted) begin
            w_frame_end = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_next_face = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // face_orient is loaded on the transition into ISSUE so it is settled before face_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      r_active      <= '0;
      r_pending_vld <= 1'b0;
      r_active_vld  <= 1'b0;
      r_aborted     <= 1'b0;
      r_face_sel    <= '0;
      r_face_orient <= '0;
      r_face_start  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_face_start <= (r_state == S_ISSUE);
      if (w_accept) begin
        r_pending     <= frame_data;
        r_pending_vld <= 1'b1;
      end
      if (w_load) begin
        r_active      <= r_pending;
        r_active_vld  <= 1'b1;
        r_pending_vld <= 1'b0;
        r_aborted     <= 1'b0;
        r_face_sel    <= '0;
        r_face_orient <= face_slice(r_pending, 3'd0);
      end
      if (w_refresh) begin
        r_aborted     <= 1'b0;
        r_face_sel    <= '0;
        r_face_orient <= face_slice(r_active, 3'd0);
      end
      if (w_next_face) begin
        r_face_sel    <= r_face_sel + 3'd1;
        r_face_orient <= face_slice(r_active, r_face_sel + 3'd1);
      end
      if (w_to_fire) begin
        r_timeout_err <= 1'b1;
        r_aborted     <= 1'b1;
      end
      if (w_frame_end && w_last_face && !r_aborted) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign frame_ready = ~r_pending_vld;
  assign face_start  = r_face_start;
  assign face_sel    = r_face_sel;
  assign face_orient = r_face_orient;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_face_frame_scheduler.sv
// Scoreboard bench: a frame-level model predicts every face_start (cycle, face, slice);
// a monitor pops and compares each face_start the DUT presents.
module tb_face_frame_scheduler;

  localparam int L  = 6;
  localparam int R  = 80;
  localparam int TO = 30;

  logic         clk;
  logic         reset;
  logic         frame_valid;
  logic [161:0] frame_data;
  logic         frame_ready;
  logic         face_start;
  logic [2:0]   face_sel;
  logic [26:0]  face_orient;
  logic         face_done;
  logic         busy;
  logic         timeout_err;
  logic [7:0]   frame_count;

  face_frame_scheduler #(
    .LATCH_CYCLES(L), .REFRESH_CYCLES(R), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_ready(frame_ready), .face_start(face_start), .face_sel(face_sel),
    .face_orient(face_orient), .face_done(face_done), .busy(busy),
    .timeout_err(timeout_err), .frame_count(frame_count)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [26:0] orient;
  } exp_t;

  exp_t exp_q[$];
  bit   done_at[int];
  int   starts[6];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_fc = 0;
  int   exp_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine: pulses face_done in the cycles the model scheduled.
  initial begin
    face_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      face_done = done_at.exists(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [161:0] rand_frame();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[161:0];
  endfunction

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Whole-frame prediction: start cycle of each face, its slice, and when the block is idle again.
  task automatic model_frame(input logic [161:0] data, input int s0, input int abort_face,
                             output int idle_at);
    int s;
    int d;
    s = s0;
    idle_at = 0;
    for (int f = 0; f < 6; f++) begin
      exp_t e;
      e.cyc = s;
      e.sel = f;
      e.orient = data[27*f +: 27];
      exp_q.push_back(e);
      starts[f] = s;
      if (f == abort_face) begin
        idle_at = s + TO + L;
        exp_err = 1;
        return;
      end
      d = $urandom_range(0, 4);
      done_at[s + d] = 1'b1;
      if (f == 5) idle_at = s + d + L + 1;
      else        s = s + d + L + 2;
    end
    exp_fc = (exp_fc + 1) % 256;
  endtask

  task automatic offer(input logic [161:0] data, input bit expect_acc, output int acc);
    frame_data  = data;
    frame_valid = 1'b1;
    @(negedge clk);
    check("frame_ready_at_offer", frame_ready, expect_acc);
    acc = cyc;
    @(posedge clk);
    #2;
    frame_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_frame_ready"}, frame_ready, 1);
    check({tag, "_face_start"}, face_start, 0);
    check({tag, "_face_sel"}, face_sel, 0);
    check({tag, "_face_orient"}, face_orient, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_frame_count"}, frame_count, 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (face_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_face_start: got face %0d at cycle %0d, required none", face_sel, cyc);
        end else begin
          e = exp_q.pop_front();
          check("face_start_cycle", cyc, e.cyc);
          check("face_sel", face_sel, e.sel);
          check("face_orient", face_orient, e.orient);
        end
      end
    end
  end

  initial begin
    int c, a, dummy, i1, i2, i3, i4, i5, ie;
    logic [161:0] fa, fb, fd, fe;
    reset = 1'b1;
    frame_valid = 1'b0;
    frame_data = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    c = cyc;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Single frame of 162'h1 from idle.
    wait_cyc(c + 2);
    offer(162'h1, 1'b1, a);
    model_frame(162'h1, a + 3, -1, i1);
    wait_cyc(i1 - 1);
    @(negedge clk);
    check("busy_last_gap", busy, 1);
    wait_cyc(i1);
    @(negedge clk);
    check("busy_after_frame", busy, 0);
    check("frame_count_1", frame_count, exp_fc);

    // Random frame, second frame offered during face 2, third refused.
    fa = rand_frame();
    wait_cyc(i1 + 2);
    offer(fa, 1'b1, a);
    model_frame(fa, a + 3, -1, i2);
    fb = rand_frame();
    wait_cyc(starts[2] + 1);
    offer(fb, 1'b1, dummy);
    repeat (3) offer(rand_frame(), 1'b0, dummy);
    model_frame(fb, i2 + 2, -1, i3);
    wait_cyc(i3);
    @(negedge clk);
    check("frame_count_3", frame_count, exp_fc);

    // No new frame: refresh re-sends the active frame.
    model_frame(fb, i3 + R + 1, -1, i4);
    wait_cyc(i4);
    @(negedge clk);
    check("frame_count_refresh", frame_count, exp_fc);
    check("timeout_err_clean", timeout_err, 0);

    // Engine stalls on face 3.
    fd = rand_frame();
    wait_cyc(i4 + 2);
    offer(fd, 1'b1, a);
    model_frame(fd, a + 3, 3, i5);
    wait_cyc(i5);
    @(negedge clk);
    check("timeout_err_set", timeout_err, exp_err);
    check("frame_count_aborted", frame_count, exp_fc);
    check("busy_after_abort", busy, 0);

    // Reset during face 1 streaming.
    fe = rand_frame();
    wait_cyc(i5 + 2);
    offer(fe, 1'b1, a);
    model_frame(fe, a + 3, -1, ie);
    wait_cyc(starts[1]);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    done_at.delete();
    exp_fc = 0;
    exp_err = 0;
    @(negedge clk);
    check_idle_outputs("mid_frame_reset");

    wait_cyc(cyc + R + 20);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_busy", busy, 0);
    check("final_frame_count", frame_count, exp_fc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
